// File: rtl/frame_slot_scheduler.sv
// rtl/frame_slot_scheduler.sv - display-domain frame-buffer slot ring scheduler
//
// Owns the DDR frame-buffer slot ring shared by the video-in writer, the
// processing software and the display reader. Events (writer frame-done,
// SW swap request, display vsync) are captured into pending flags and serviced
// one per cycle by a small FSM with priority WR > SW > VS.
//
// Ports:
//   disp_clk_i       display clock, sole clock
//   resetn_i         synchronous active-low reset
//   wr_done_i        1-cycle pulse, writer finished its current slot
//   vsync_i          1-cycle pulse, display frame start
//   swap_toggle_i    SW swap request, every edge is one request
//   min_delay_sel_i  1: display newest written frame, 0: display processed frame
//   wr_addr_o        {BASE_MSB[7:3], wr_slot}
//   rd_addr_o        {BASE_MSB[7:3], rd_slot}
//   proc_addr_o      {BASE_MSB[7:3], proc_slot}
//   ready_valid_o    a complete frame not yet taken by SW exists
//   swap_ack_o       1-cycle pulse, swap request serviced
//   swap_new_o       qualifies swap_ack_o, proc moved to a new frame
//   drop_cnt_o       saturating count of ready frames overwritten before SW took them
//   error_o          sticky, writer slot collided with rd or proc slot

module frame_slot_scheduler #(
    parameter int          NUM_SLOTS = 4,
    parameter logic [7:0]  BASE_MSB  = 8'h70,
    parameter int          DROP_W    = 16
) (
    input  logic              disp_clk_i,
    input  logic              resetn_i,
    input  logic              wr_done_i,
    input  logic              vsync_i,
    input  logic              swap_toggle_i,
    input  logic              min_delay_sel_i,
    output logic [7:0]        wr_addr_o,
    output logic [7:0]        rd_addr_o,
    output logic [7:0]        proc_addr_o,
    output logic              ready_valid_o,
    output logic              swap_ack_o,
    output logic              swap_new_o,
    output logic [DROP_W-1:0] drop_cnt_o,
    output logic              error_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SVC_WR = 2'd1,
        SVC_SW = 2'd2,
        SVC_VS = 2'd3
    } state_t;

    localparam logic [DROP_W-1:0] DROP_MAX = {DROP_W{1'b1}};

    state_t state, state_n;

    logic [2:0]        wr_slot, rd_slot, proc_slot, ready_slot;
    logic [2:0]        wr_slot_n, rd_slot_n, proc_slot_n, ready_slot_n;
    logic              ready_valid, ready_valid_n;
    logic [DROP_W-1:0] drop_cnt, drop_cnt_n;
    logic              error_q, error_n;
    logic              swap_ack_n, swap_new_n;

    logic              pend_wr, pend_sw, pend_vs;
    logic              swap_q;
    logic              swap_ev;
    logic              in_service;

    logic [2:0]        free_slot;
    logic              free_found;

    assign swap_ev    = swap_toggle_i ^ swap_q;
    assign in_service = (state != IDLE);

    // Lowest-index slot that is free once the finished slot has become READY
    // and the previous READY slot has been released: the only remaining owners
    // are the finished slot (old wr_slot), rd and proc.
    always_comb begin
        free_slot  = 3'd0;
        free_found = 1'b0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if ((3'(i) != wr_slot) && (3'(i) != rd_slot) && (3'(i) != proc_slot)) begin
                free_slot  = 3'(i);
                free_found = 1'b1;
            end
        end
    end

    // Next-state: every state (service states included) returns through the
    // IDLE decision, so back-to-back pending events are serviced on
    // consecutive cycles without a dead IDLE cycle in between.
    always_comb begin
        state_n = IDLE;
        if (pend_wr) begin
            state_n = SVC_WR;
        end else if (pend_sw) begin
            state_n = SVC_SW;
        end else if (pend_vs) begin
            state_n = SVC_VS;
        end
    end

    // Service datapath: pointers only move in service states.
    always_comb begin
        wr_slot_n     = wr_slot;
        rd_slot_n     = rd_slot;
        proc_slot_n   = proc_slot;
        ready_slot_n  = ready_slot;
        ready_valid_n = ready_valid;
        drop_cnt_n    = drop_cnt;
        swap_ack_n    = 1'b0;
        swap_new_n    = 1'b0;
        error_n       = error_q;

        case (state)
            SVC_WR: begin
                // Previous READY frame still untaken by SW is overwritten.
                if (ready_valid && (drop_cnt != DROP_MAX)) begin
                    drop_cnt_n = drop_cnt + 1'b1;
                end
                ready_slot_n  = wr_slot;
                ready_valid_n = 1'b1;
                if (free_found) begin
                    wr_slot_n = free_slot;
                end
            end
            SVC_SW: begin
                swap_ack_n = 1'b1;
                if (ready_valid) begin
                    proc_slot_n   = ready_slot;
                    ready_valid_n = 1'b0;
                    swap_new_n    = 1'b1;
                end
            end
            SVC_VS: begin
                if (!min_delay_sel_i) begin
                    rd_slot_n = proc_slot;
                end else if (ready_valid) begin
                    // READY stays set so SW can still take this frame.
                    rd_slot_n = ready_slot;
                end
            end
            default: begin
            end
        endcase

        if (in_service && ((wr_slot_n == rd_slot_n) || (wr_slot_n == proc_slot_n))) begin
            error_n = 1'b1;
        end
    end

    always_ff @(posedge disp_clk_i) begin
        if (!resetn_i) begin
            state       <= IDLE;
            wr_slot     <= 3'd0;
            rd_slot     <= 3'd1;
            proc_slot   <= 3'd1;
            ready_slot  <= 3'd0;
            ready_valid <= 1'b0;
            drop_cnt    <= '0;
            error_q     <= 1'b0;
            swap_ack_o  <= 1'b0;
            swap_new_o  <= 1'b0;
            pend_wr     <= 1'b0;
            pend_sw     <= 1'b0;
            pend_vs     <= 1'b0;
            // Track the current toggle level so leaving reset is not a request.
            swap_q      <= swap_toggle_i;
        end else begin
            state       <= state_n;
            wr_slot     <= wr_slot_n;
            rd_slot     <= rd_slot_n;
            proc_slot   <= proc_slot_n;
            ready_slot  <= ready_slot_n;
            ready_valid <= ready_valid_n;
            drop_cnt    <= drop_cnt_n;
            error_q     <= error_n;
            swap_ack_o  <= swap_ack_n;
            swap_new_o  <= swap_new_n;
            swap_q      <= swap_toggle_i;
            // A flag is cleared on entry to its service; a new event arriving
            // in that same cycle re-arms it, repeats while pending merge.
            pend_wr     <= (pend_wr & (state_n != SVC_WR)) | wr_done_i;
            pend_sw     <= (pend_sw & (state_n != SVC_SW)) | swap_ev;
            pend_vs     <= (pend_vs & (state_n != SVC_VS)) | vsync_i;
        end
    end

    assign wr_addr_o     = {BASE_MSB[7:3], wr_slot};
    assign rd_addr_o     = {BASE_MSB[7:3], rd_slot};
    assign proc_addr_o   = {BASE_MSB[7:3], proc_slot};
    assign ready_valid_o = ready_valid;
    assign drop_cnt_o    = drop_cnt;
    assign error_o       = error_q;

endmodule
